// File: rtl/led_cmd_parser.sv
// UART command parser: consumes "C<hex><hex>\r" frames from an RX FIFO, updates the LED colour
// and optionally answers each accepted/rejected frame with 'K' or 'E' over the UART transmitter.
module led_cmd_parser #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter bit          ACK_EN         = 1'b1
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       i_Fifo_Not_Empty,
    output logic       o_Read_FIFO,
    input  logic [7:0] i_Fifo_Data,
    output logic       o_Tx_Start,
    output logic [7:0] o_Tx_Data,
    input  logic       i_Tx_Busy,
    output logic [7:0] o_Colour,
    output logic       o_Colour_Valid,
    output logic       o_Error
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]  CH_C  = 8'h43;
    localparam logic [7:0]  CH_CR = 8'h0D;
    localparam logic [7:0]  CH_K  = 8'h4B;
    localparam logic [7:0]  CH_E  = 8'h45;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_FETCH,
        ST_DECODE,
        ST_REPLY
    } state_t;

    state_t           state, state_next;
    logic [1:0]       pos, pos_next;
    logic [3:0]       hi, hi_next;
    logic [3:0]       lo, lo_next;
    logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
    logic [7:0]       reply, reply_next;
    logic             read_next;
    logic             start_next;
    logic [7:0]       tx_data_next;
    logic [7:0]       colour_next;
    logic             colour_valid_next;
    logic             error_next;
    logic             frame_ok;
    logic             frame_bad;
    logic [4:0]       hex_val;

    // {valid, nibble} for an ASCII hex digit, either case.
    function automatic logic [4:0] to_nibble(input logic [7:0] b);
        logic [4:0] r;
        r = 5'b0;
        if (b >= 8'h30 && b <= 8'h39) begin
            r = {1'b1, b[3:0]};
        end else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66)) begin
            r = {1'b1, 4'(b[3:0] + 4'd9)};
        end
        return r;
    endfunction

    assign hex_val = to_nibble(i_Fifo_Data);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state          <= ST_WAIT;
            pos            <= 2'd0;
            hi             <= 4'd0;
            lo             <= 4'd0;
            cnt            <= '0;
            reply          <= 8'h00;
            o_Read_FIFO    <= 1'b0;
            o_Tx_Start     <= 1'b0;
            o_Tx_Data      <= 8'h00;
            o_Colour       <= 8'h00;
            o_Colour_Valid <= 1'b0;
            o_Error        <= 1'b0;
        end else begin
            state          <= state_next;
            pos            <= pos_next;
            hi             <= hi_next;
            lo             <= lo_next;
            cnt            <= cnt_next;
            reply          <= reply_next;
            o_Read_FIFO    <= read_next;
            o_Tx_Start     <= start_next;
            o_Tx_Data      <= tx_data_next;
            o_Colour       <= colour_next;
            o_Colour_Valid <= colour_valid_next;
            o_Error        <= error_next;
        end
    end

    always_comb begin
        state_next        = state;
        pos_next          = pos;
        hi_next           = hi;
        lo_next           = lo;
        cnt_next          = cnt;
        cnt_inc           = cnt + CNT_W'(1);
        reply_next        = reply;
        read_next         = 1'b0;
        start_next        = 1'b0;
        tx_data_next      = o_Tx_Data;
        colour_next       = o_Colour;
        colour_valid_next = 1'b0;
        error_next        = 1'b0;
        frame_ok          = 1'b0;
        frame_bad         = 1'b0;

        // Inter-byte timeout; a DECODE cycle overrides it below.
        if (state != ST_DECODE && pos != 2'd0) begin
            if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
                pos_next = 2'd0;
                hi_next  = 4'd0;
                lo_next  = 4'd0;
                cnt_next = '0;
            end else begin
                cnt_next = cnt_inc;
            end
        end

        case (state)
            ST_WAIT: begin
                if (i_Fifo_Not_Empty) begin
                    read_next  = 1'b1;
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_next = ST_DECODE;
            end
            ST_DECODE: begin
                cnt_next   = '0;
                state_next = ST_WAIT;
                case (pos)
                    2'd0: begin
                        if (i_Fifo_Data == CH_C) pos_next = 2'd1;
                    end
                    2'd1: begin
                        if (hex_val[4]) begin
                            hi_next  = hex_val[3:0];
                            pos_next = 2'd2;
                        end else begin
                            frame_bad = 1'b1;
                        end
                    end
                    2'd2: begin
                        if (hex_val[4]) begin
                            lo_next  = hex_val[3:0];
                            pos_next = 2'd3;
                        end else begin
                            frame_bad = 1'b1;
                        end
                    end
                    default: begin
                        if (i_Fifo_Data == CH_CR) frame_ok = 1'b1;
                        else frame_bad = 1'b1;
                    end
                endcase
                if (frame_ok) begin
                    colour_next       = {hi, lo};
                    colour_valid_next = 1'b1;
                    reply_next        = CH_K;
                end
                if (frame_bad) begin
                    error_next = 1'b1;
                    reply_next = CH_E;
                end
                if (frame_ok || frame_bad) begin
                    pos_next = 2'd0;
                    hi_next  = 4'd0;
                    lo_next  = 4'd0;
                    if (ACK_EN) state_next = ST_REPLY;
                end
            end
            default: begin
                if (!i_Tx_Busy) begin
                    start_next   = 1'b1;
                    tx_data_next = reply;
                    state_next   = ST_WAIT;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_led_cmd_parser.sv
// Scoreboard bench for led_cmd_parser: stimulus pushes bytes into a FIFO model and queues the
// expected colour/error/reply events; a negedge monitor pops and compares as the DUT responds.
module tb_led_cmd_parser;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       fifo_not_empty;
    logic       read_fifo;
    logic [7:0] fifo_data;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic [7:0] colour;
    logic       colour_valid;
    logic       error;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] fifo_mem [0:63];
    int         wr_ptr = 0;
    int         rd_ptr = 0;

    logic [7:0] exp_colour [$];
    logic [7:0] exp_tx     [$];
    bit         exp_error  [$];
    logic [7:0] cur_colour;

    always #5 Clock = ~Clock;

    led_cmd_parser #(
        .TIMEOUT_CYCLES(16),
        .ACK_EN        (1'b1)
    ) dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .i_Fifo_Not_Empty(fifo_not_empty),
        .o_Read_FIFO     (read_fifo),
        .i_Fifo_Data     (fifo_data),
        .o_Tx_Start      (tx_start),
        .o_Tx_Data       (tx_data),
        .i_Tx_Busy       (tx_busy),
        .o_Colour        (colour),
        .o_Colour_Valid  (colour_valid),
        .o_Error         (error)
    );

    assign fifo_not_empty = (wr_ptr != rd_ptr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_cmp++;
        n_err++;
        $display("FAIL %s: unexpected pulse, value 0x%0h, expected no pulse at %0t", name, act, $time);
    endtask

    // FIFO model: head byte appears just after the edge that follows a pop request.
    always @(negedge Clock) begin
        if (!Reset && read_fifo) begin
            @(posedge Clock);
            #1;
            if (rd_ptr != wr_ptr) begin
                fifo_data = fifo_mem[rd_ptr];
                rd_ptr    = rd_ptr + 1;
            end
        end
    end

    // Monitor: pop and compare on each output pulse.
    always @(negedge Clock) begin
        if (Reset) begin
            cur_colour = 8'h00;
        end else begin
            if (colour_valid) begin
                if (exp_colour.size() == 0) unexpected("colour_valid", 32'(colour));
                else begin
                    cur_colour = exp_colour.pop_front();
                    check("colour", 32'(colour), 32'(cur_colour));
                end
            end
            if (error) begin
                if (exp_error.size() == 0) unexpected("error", 32'(colour));
                else begin
                    void'(exp_error.pop_front());
                    check("colour_held_on_error", 32'(colour), 32'(cur_colour));
                end
            end
            if (tx_start) begin
                if (exp_tx.size() == 0) unexpected("tx_start", 32'(tx_data));
                else check("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge Clock);
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        push(b0);
        push(b1);
        push(b2);
        push(b3);
    endtask

    task automatic expect_ok(input logic [7:0] c);
        exp_colour.push_back(c);
        exp_tx.push_back(8'h4B);
    endtask

    task automatic expect_err();
        exp_error.push_back(1'b1);
        exp_tx.push_back(8'h45);
    endtask

    task automatic wait_ptr(input string name, input int target);
        int i;
        for (i = 0; i < 300 && rd_ptr < target; i++) @(negedge Clock);
        if (rd_ptr < target) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: FIFO read pointer %0d, expected %0d within 300 cycles", name, rd_ptr, target);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_read_fifo"},    32'(read_fifo),    32'd0);
        check({tag, "_tx_start"},     32'(tx_start),     32'd0);
        check({tag, "_tx_data"},      32'(tx_data),      32'h00);
        check({tag, "_colour"},       32'(colour),       32'h00);
        check({tag, "_colour_valid"}, 32'(colour_valid), 32'd0);
        check({tag, "_error"},        32'(error),        32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int reads;
        int starts;
        Reset     = 1'b1;
        tx_busy   = 1'b0;
        fifo_data = 8'h00;
        idle(3);
        check_reset_values("reset");
        Reset = 1'b0;
        idle(2);

        // Plain accepted frame.
        expect_ok(8'h7F);
        push_frame(8'h43, 8'h37, 8'h66, 8'h0D);
        wait_ptr("frame_7f", wr_ptr);
        idle(10);

        // Non-hex low digit; the trailing CR is then just noise.
        expect_err();
        push_frame(8'h43, 8'h31, 8'h47, 8'h0D);
        wait_ptr("frame_err", wr_ptr);
        idle(10);

        // Leading junk discarded silently, then uppercase hex.
        expect_ok(8'hAB);
        push(8'h0A);
        push(8'h55);
        push_frame(8'h43, 8'h41, 8'h42, 8'h0D);
        wait_ptr("frame_ab", wr_ptr);
        idle(10);

        // Transmitter busy across the reply, with a byte waiting in the FIFO.
        tx_busy = 1'b1;
        expect_ok(8'h9D);
        push_frame(8'h43, 8'h39, 8'h64, 8'h0D);
        push(8'h55);
        wait_ptr("frame_busy", wr_ptr - 1);
        reads  = 0;
        starts = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clock);
            if (read_fifo) reads++;
            if (tx_start) starts++;
        end
        check("no_read_while_busy", 32'(reads), 32'd0);
        check("no_start_while_busy", 32'(starts), 32'd0);
        tx_busy = 1'b0;
        @(negedge Clock);
        check("start_after_busy_falls", 32'(tx_start), 32'd1);
        idle(10);

        // Partial frame times out; its remaining bytes are discarded.
        push(8'h43);
        push(8'h31);
        wait_ptr("timeout_head", wr_ptr);
        idle(20);
        push(8'h32);
        push(8'h0D);
        wait_ptr("timeout_tail", wr_ptr);
        idle(10);
        expect_ok(8'h5A);
        push_frame(8'h43, 8'h35, 8'h61, 8'h0D);
        wait_ptr("frame_after_timeout", wr_ptr);
        idle(10);

        // Reset in the middle of a frame.
        push(8'h43);
        push(8'h35);
        wait_ptr("reset_head", wr_ptr);
        idle(1);
        Reset = 1'b1;
        idle(2);
        check_reset_values("midframe_reset");
        Reset = 1'b0;
        idle(2);
        expect_ok(8'h01);
        push_frame(8'h43, 8'h30, 8'h31, 8'h0D);
        wait_ptr("frame_01", wr_ptr);
        idle(10);

        check("pending_colour_events", 32'(exp_colour.size()), 32'd0);
        check("pending_error_events",  32'(exp_error.size()),  32'd0);
        check("pending_tx_events",     32'(exp_tx.size()),     32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
